// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage: word geometry, PC step and
// MIPS instruction field boundaries.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

endpackage

// File: rtl/fetch_checker.sv
// Protocol assertions for the fetch stage: buffer overflow and responses
// arriving with nothing in flight.
module fetch_checker (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full,
   input logic rsp_valid,
   input logic out_zero
);

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);

   a_rsp_has_credit: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> !out_zero);

endmodule

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries; registered
// storage, no write-to-read bypass, flush empties it in one cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Status flags, qualified handshakes and head-of-queue read.
   always_comb begin
      full      = (count_r == (PTR_W+1)'(DEPTH));
      empty     = (count_r == {(PTR_W+1){1'b0}});
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      count     = count_r;
      rdata     = mem_r[rd_ptr_r];
   end

   // Storage and pointers; reset clears the array so the head reads as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_r + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
      end
   end

endmodule

// File: rtl/etapa_fetch.sv
// Instruction fetch stage: credit-limited in-order requests, response buffer,
// redirect flush with discard of in-flight words. Optional FETCH_PERF_EN adds
// fetched/flushed performance counters.
module etapa_fetch
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [31:0]       dec_instr,
   output logic [5:0]        dec_opcode,
   output logic [4:0]        dec_rs,
   output logic [4:0]        dec_rt,
   output logic [4:0]        dec_rd,
   output logic [5:0]        dec_funct
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] rsp_pc_r;
   logic [CNT_W-1:0]  out_r;
   logic [CNT_W-1:0]  disc_r;
   logic [CNT_W-1:0]  fifo_count_s;
   logic [CNT_W:0]    inflight_s;
   logic [ADDR_W-1:0] redir_pc_s;
   logic [ENT_W-1:0]  head_s;
   logic              req_fire_s;
   logic              rsp_ok_s;
   logic              keep_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              redir_lsb_unused_s;

   // Credit, handshake qualification and decode field split.
   always_comb begin
      redir_pc_s         = {redirect_pc[ADDR_W-1:2], 2'b00};
      redir_lsb_unused_s = ^redirect_pc[1:0];
      inflight_s         = {1'b0, out_r} + {1'b0, fifo_count_s};
      imem_req_valid     = !rst && (inflight_s < (CNT_W+1)'(FIFO_DEPTH)) && !redirect_valid;
      imem_req_addr      = pc_r;
      req_fire_s         = imem_req_valid && imem_req_ready;
      rsp_ok_s           = imem_rsp_valid && (out_r != {CNT_W{1'b0}});
      // A response is kept only when no stale words remain and no flush is happening.
      keep_s             = rsp_ok_s && (disc_r == {CNT_W{1'b0}}) && !redirect_valid;
      pop_s              = !fifo_empty_s && dec_ready && !redirect_valid;
      dec_valid          = !fifo_empty_s;
      dec_pc             = head_s[ENT_W-1:INSTR_W];
      dec_instr          = head_s[INSTR_W-1:0];
      dec_opcode         = dec_instr[OPCODE_MSB:OPCODE_LSB];
      dec_rs             = dec_instr[RS_MSB:RS_LSB];
      dec_rt             = dec_instr[RT_MSB:RT_LSB];
      dec_rd             = dec_instr[RD_MSB:RD_LSB];
      dec_funct          = dec_instr[FUNCT_MSB:FUNCT_LSB];
   end

   // PC, response-PC tag, in-flight and discard counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r     <= RESET_PC;
         rsp_pc_r <= RESET_PC;
         out_r    <= {CNT_W{1'b0}};
         disc_r   <= {CNT_W{1'b0}};
      end else begin
         out_r <= out_r + CNT_W'(req_fire_s) - CNT_W'(rsp_ok_s);
         if (redirect_valid) begin
            pc_r     <= redir_pc_s;
            rsp_pc_r <= redir_pc_s;
            disc_r   <= out_r - CNT_W'(rsp_ok_s);
         end else begin
            if (req_fire_s) begin
               pc_r <= pc_r + ADDR_W'(PC_STEP);
            end
            if (keep_s) begin
               rsp_pc_r <= rsp_pc_r + ADDR_W'(PC_STEP);
            end
            if (rsp_ok_s && (disc_r != {CNT_W{1'b0}})) begin
               disc_r <= disc_r - CNT_W'(1);
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (keep_s),
      .pop   (pop_s),
      .flush (redirect_valid),
      .wdata ({rsp_pc_r, imem_rsp_data}),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   fetch_checker u_checker (
      .clk       (clk),
      .rst       (rst),
      .push      (keep_s),
      .full      (fifo_full_s),
      .rsp_valid (imem_rsp_valid),
      .out_zero  (out_r == {CNT_W{1'b0}})
   );

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_r;
   logic [31:0] perf_flushed_r;

   // Delivered and dropped instruction counters; flush counts every buffered entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_r <= 32'd0;
         perf_flushed_r <= 32'd0;
      end else begin
         perf_fetched_r <= perf_fetched_r + 32'(pop_s);
         perf_flushed_r <= perf_flushed_r
                           + (redirect_valid ? 32'(fifo_count_s) : 32'd0)
                           + 32'(rsp_ok_s && !keep_s);
      end
   end

   assign perf_fetched = perf_fetched_r;
   assign perf_flushed = perf_flushed_r;
`endif

endmodule
